sint_window_minmax: RTL

- Streaming reducer that sits directly upstream of the signed less-than compare stage.
- Accepts a stream of signed WIDTH-bit samples over a valid/ready handshake.
- For every WINDOW consecutive accepted samples, finds the signed minimum and maximum and the index of each, then presents the result on a valid/ready output.
- The signed compare stage consumes MIN/MAX as its operand pair, for range and threshold checks.

---
 rtl/sint_window_minmax_pkg.sv | 30 +++
 rtl/sint_window_minmax_if.sv | 31 +++
 rtl/sint_minmax_update.sv | 44 ++++
 rtl/sint_window_minmax.sv | 133 +++++++++++++
 4 files changed

// File: rtl/sint_window_minmax_pkg.sv
// Shared types and helpers for the windowed signed min/max reducer.
package sint_window_minmax_pkg;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_e;

    // Width of a sample, widened only for the shared signed compare.
    localparam int unsigned SLT_W = 32;

    // Ceiling log2, floored at 1 so an index port is never zero-width.
    function automatic int unsigned idx_w(input int unsigned n);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(n)) begin
                w = i + 1;
            end
        end
        return (w == 0) ? 1 : w;
    endfunction

    // Signed less-than, same semantics as the downstream slt compare stage.
    function automatic logic slt(input logic signed [SLT_W-1:0] a,
                                 input logic signed [SLT_W-1:0] b);
        return a < b;
    endfunction

endpackage

// File: rtl/sint_window_minmax_if.sv
// Sample-in / result-out handshake bundle for sint_window_minmax.
interface sint_window_minmax_if
    import sint_window_minmax_pkg::*;
#(
    parameter int unsigned WIDTH  = 3,
    parameter int unsigned WINDOW = 4
) ();

    localparam int unsigned IDXW = idx_w(WINDOW);

    logic [WIDTH-1:0] I;
    logic             I_valid;
    logic             I_ready;
    logic [WIDTH-1:0] MIN;
    logic [WIDTH-1:0] MAX;
    logic [IDXW-1:0]  MIN_IDX;
    logic [IDXW-1:0]  MAX_IDX;
    logic             O_valid;
    logic             O_ready;

    modport slave (
        input  I, I_valid, O_ready,
        output I_ready, MIN, MAX, MIN_IDX, MAX_IDX, O_valid
    );

    modport master (
        output I, I_valid, O_ready,
        input  I_ready, MIN, MAX, MIN_IDX, MAX_IDX, O_valid
    );

endinterface

// File: rtl/sint_minmax_update.sv
// Running min/max step: folds one sample into the current extremes.
module sint_minmax_update
    import sint_window_minmax_pkg::*;
#(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned IDXW  = 2
) (
    input  logic signed [WIDTH-1:0] sample_i,
    input  logic signed [WIDTH-1:0] run_min_i,
    input  logic signed [WIDTH-1:0] run_max_i,
    input  logic        [IDXW-1:0]  min_idx_i,
    input  logic        [IDXW-1:0]  max_idx_i,
    input  logic        [IDXW-1:0]  k_i,
    input  logic                    first_i,
    output logic signed [WIDTH-1:0] min_o,
    output logic signed [WIDTH-1:0] max_o,
    output logic        [IDXW-1:0]  min_idx_o,
    output logic        [IDXW-1:0]  max_idx_o
);

    // Strict compares so a tie keeps the earlier index.
    always_comb begin
        min_o     = run_min_i;
        max_o     = run_max_i;
        min_idx_o = min_idx_i;
        max_idx_o = max_idx_i;
        if (first_i) begin
            min_o     = sample_i;
            max_o     = sample_i;
            min_idx_o = '0;
            max_idx_o = '0;
        end else begin
            if (slt(SLT_W'(sample_i), SLT_W'(run_min_i))) begin
                min_o     = sample_i;
                min_idx_o = k_i;
            end
            if (slt(SLT_W'(run_max_i), SLT_W'(sample_i))) begin
                max_o     = sample_i;
                max_idx_o = k_i;
            end
        end
    end

endmodule

// File: rtl/sint_window_minmax.sv
// Windowed signed min/max reducer: WINDOW accepted samples -> one result.
module sint_window_minmax
    import sint_window_minmax_pkg::*;
#(
    parameter int unsigned WIDTH  = 3,
    parameter int unsigned WINDOW = 4
) (
    input  logic                CLK,
    input  logic                RESET,
    sint_window_minmax_if.slave bus
);

    localparam int unsigned     IDXW   = idx_w(WINDOW);
    localparam logic [IDXW-1:0] LAST_K = IDXW'(WINDOW - 1);

    state_e                  state_q, state_d;
    logic       [IDXW-1:0]   count_q, count_d;
    logic signed [WIDTH-1:0] run_min_q, run_min_d;
    logic signed [WIDTH-1:0] run_max_q, run_max_d;
    logic       [IDXW-1:0]   run_min_idx_q, run_min_idx_d;
    logic       [IDXW-1:0]   run_max_idx_q, run_max_idx_d;
    logic       [WIDTH-1:0]  min_q, min_d;
    logic       [WIDTH-1:0]  max_q, max_d;
    logic       [IDXW-1:0]   min_idx_q, min_idx_d;
    logic       [IDXW-1:0]   max_idx_q, max_idx_d;

    logic signed [WIDTH-1:0] upd_min, upd_max;
    logic       [IDXW-1:0]   upd_min_idx, upd_max_idx;
    logic                    accept;

    assign accept = bus.I_valid && (state_q == ST_ACCUM);

    sint_minmax_update #(
        .WIDTH (WIDTH),
        .IDXW  (IDXW)
    ) u_update (
        .sample_i  ($signed(bus.I)),
        .run_min_i (run_min_q),
        .run_max_i (run_max_q),
        .min_idx_i (run_min_idx_q),
        .max_idx_i (run_max_idx_q),
        .k_i       (count_q),
        .first_i   (count_q == '0),
        .min_o     (upd_min),
        .max_o     (upd_max),
        .min_idx_o (upd_min_idx),
        .max_idx_o (upd_max_idx)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, window counter and running/result register updates.
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        run_min_d     = run_min_q;
        run_max_d     = run_max_q;
        run_min_idx_d = run_min_idx_q;
        run_max_idx_d = run_max_idx_q;
        min_d         = min_q;
        max_d         = max_q;
        min_idx_d     = min_idx_q;
        max_idx_d     = max_idx_q;
        case (state_q)
            ST_ACCUM: begin
                if (accept) begin
                    run_min_d     = upd_min;
                    run_max_d     = upd_max;
                    run_min_idx_d = upd_min_idx;
                    run_max_idx_d = upd_max_idx;
                    if (count_q == LAST_K) begin
                        min_d     = upd_min;
                        max_d     = upd_max;
                        min_idx_d = upd_min_idx;
                        max_idx_d = upd_max_idx;
                        count_d   = '0;
                        state_d   = ST_HOLD;
                    end else begin
                        count_d = count_q + IDXW'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (bus.O_ready) begin
                    state_d = ST_ACCUM;
                end
            end
            default: begin
                state_d = ST_ACCUM;
            end
        endcase
    end

    // Datapath registers; reset drops any partial window or pending result.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            count_q       <= '0;
            run_min_q     <= '0;
            run_max_q     <= '0;
            run_min_idx_q <= '0;
            run_max_idx_q <= '0;
            min_q         <= '0;
            max_q         <= '0;
            min_idx_q     <= '0;
            max_idx_q     <= '0;
        end else begin
            count_q       <= count_d;
            run_min_q     <= run_min_d;
            run_max_q     <= run_max_d;
            run_min_idx_q <= run_min_idx_d;
            run_max_idx_q <= run_max_idx_d;
            min_q         <= min_d;
            max_q         <= max_d;
            min_idx_q     <= min_idx_d;
            max_idx_q     <= max_idx_d;
        end
    end

    assign bus.I_ready = (state_q == ST_ACCUM);
    assign bus.O_valid = (state_q == ST_HOLD);
    assign bus.MIN     = min_q;
    assign bus.MAX     = max_q;
    assign bus.MIN_IDX = min_idx_q;
    assign bus.MAX_IDX = max_idx_q;

endmodule
